// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_unit: branch compare/resolve with 2-bit bimodal PHT         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int PHT_DEPTH = 16,
  parameter int IDX_LSB   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             pred_taken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] res_pc,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val_src2,
  input  logic [2:0]       Br_type,
  input  logic             res_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Br_taken,
  output logic             mispredict,
  output logic [15:0]      mispred_count
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  localparam logic [2:0] c_idle = 3'b000;
  localparam logic [2:0] c_bez  = 3'b001;
  localparam logic [2:0] c_bne  = 3'b010;
  localparam logic [2:0] c_jmp  = 3'b011;
  localparam logic [2:0] c_beq  = 3'b100;
  localparam logic [2:0] c_blt  = 3'b101;
  localparam logic [2:0] c_bge  = 3'b110;

  logic [1:0]       r_pht [PHT_DEPTH];
  logic [IDX_W-1:0] w_lookup_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic             w_accept;
  logic             w_taken;
  logic             w_cond;
  logic             w_mispred;
  logic [1:0]       w_ctr;

  // Upper PC bits fall away in the cast, so distinct PCs may alias.
  assign w_lookup_idx = IDX_W'(lookup_pc >> IDX_LSB);
  assign w_res_idx    = IDX_W'(res_pc >> IDX_LSB);

  assign pred_taken = r_pht[w_lookup_idx][1];
  assign in_ready   = !out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_ctr      = r_pht[w_res_idx];

  always_comb begin
    w_taken = 1'b0;
    case (Br_type)
      c_idle:  w_taken = 1'b0;
      c_bez:   w_taken = (val1 == '0);
      c_bne:   w_taken = (val1 != val_src2);
      c_jmp:   w_taken = 1'b1;
      c_beq:   w_taken = (val1 == val_src2);
      c_blt:   w_taken = ($signed(val1) < $signed(val_src2));
      c_bge:   w_taken = ($signed(val1) >= $signed(val_src2));
      default: w_taken = (val1 < val_src2);
    endcase
  end

  assign w_cond    = (Br_type != c_idle) && (Br_type != c_jmp);
  assign w_mispred = (Br_type != c_idle) && (w_taken != res_pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      Br_taken      <= 1'b0;
      mispredict    <= 1'b0;
      mispred_count <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (w_accept) begin
      out_valid  <= 1'b1;
      Br_taken   <= w_taken;
      mispredict <= w_mispred;
      if (w_mispred && (mispred_count != 16'hFFFF)) begin
        mispred_count <= mispred_count + 16'd1;
      end
      if (w_cond) begin
        if (w_taken && (w_ctr != 2'b11)) begin
          r_pht[w_res_idx] <= w_ctr + 2'd1;
        end else if (!w_taken && (w_ctr != 2'b00)) begin
          r_pht[w_res_idx] <= w_ctr - 2'd1;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_resolve_unit: directed scoreboard bench for branch_resolve_unit  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_branch_resolve_unit;

  localparam int WIDTH     = 32;
  localparam int PHT_DEPTH = 16;
  localparam int IDX_LSB   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] lookup_pc;
  logic             pred_taken;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res_pc;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val_src2;
  logic [2:0]       Br_type;
  logic             res_pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             Br_taken;
  logic             mispredict;
  logic [15:0]      mispred_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .WIDTH    (WIDTH),
    .PHT_DEPTH(PHT_DEPTH),
    .IDX_LSB  (IDX_LSB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (lookup_pc),
    .pred_taken    (pred_taken),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .res_pc        (res_pc),
    .val1          (val1),
    .val_src2      (val_src2),
    .Br_type       (Br_type),
    .res_pred_taken(res_pred_taken),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .Br_taken      (Br_taken),
    .mispredict    (mispredict),
    .mispred_count (mispred_count)
  );

  typedef struct packed {
    logic taken;
    logic mis;
  } res_t;

  int          checks   = 0;
  int          failures = 0;
  res_t        sb[$];
  logic [1:0]  m_pht [PHT_DEPTH];
  logic [15:0] m_cnt;
  logic        m_valid;

  function automatic logic model_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'd0:    return 1'b0;
      3'd1:    return a == 32'd0;
      3'd2:    return a != b;
      3'd3:    return 1'b1;
      3'd4:    return a == b;
      3'd5:    return $signed(a) < $signed(b);
      3'd6:    return $signed(a) >= $signed(b);
      default: return a < b;
    endcase
  endfunction

  function automatic int pidx(input logic [31:0] pc);
    return int'((pc >> IDX_LSB) % PHT_DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid = 1'b0;
    m_cnt   = 16'd0;
    for (int i = 0; i < PHT_DEPTH; i++) m_pht[i] = 2'b01;
  endtask

  // One clock: checks pre-edge combinational outputs, advances the model,
  // then checks the registered outputs against the scoreboard head.
  task automatic tick(input string tag);
    res_t r;
    logic acc;
    logic hs;
    int   k;
    #1;
    chk({tag, ":in_ready"}, in_ready, !m_valid || out_ready);
    chk({tag, ":pred"}, pred_taken, m_pht[pidx(lookup_pc)][1]);
    hs  = m_valid && out_ready;
    acc = in_valid && (!m_valid || out_ready);
    if (rst) begin
      model_reset();
    end else begin
      if (hs) void'(sb.pop_front());
      if (acc) begin
        r.taken = model_taken(Br_type, val1, val_src2);
        r.mis   = (Br_type != 3'd0) && (r.taken != res_pred_taken);
        sb.push_back(r);
        if (r.mis && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (Br_type != 3'd0 && Br_type != 3'd3) begin
          k = pidx(res_pc);
          if (r.taken && m_pht[k] != 2'b11) m_pht[k] = m_pht[k] + 2'd1;
          else if (!r.taken && m_pht[k] != 2'b00) m_pht[k] = m_pht[k] - 2'd1;
        end
      end
      m_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
    end
    @(posedge clk);
    #1;
    chk({tag, ":out_valid"}, out_valid, m_valid);
    if (m_valid && sb.size() > 0) begin
      chk({tag, ":taken"}, Br_taken, sb[0].taken);
      chk({tag, ":mispred"}, mispredict, sb[0].mis);
    end
    chk({tag, ":count"}, mispred_count, m_cnt);
  endtask

  task automatic req(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] pc, input logic p);
    in_valid       = 1'b1;
    Br_type        = t;
    val1           = a;
    val_src2       = b;
    res_pc         = pc;
    res_pred_taken = p;
    lookup_pc      = pc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; lookup_pc = '0; res_pc = '0;
    val1 = '0; val_src2 = '0; Br_type = 3'd0; res_pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    lookup_pc = 32'h40;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", mispred_count, 0);
    chk("rst_pred_40", pred_taken, 0);

    // BEQ taken against a not-taken prediction
    req(3'd4, 32'd5, 32'd5, 32'h40, 1'b0);
    tick("beq");
    chk("beq_taken", Br_taken, 1);
    chk("beq_mispred", mispredict, 1);
    chk("beq_count", mispred_count, 1);
    in_valid = 1'b0; lookup_pc = 32'h40;
    #1;
    chk("beq_pred_40", pred_taken, 1);
    tick("drain0");

    req(3'd5, 32'hFFFF_FFFF, 32'd1, 32'h200, 1'b0);
    tick("blt");
    chk("blt_taken", Br_taken, 1);
    req(3'd7, 32'hFFFF_FFFF, 32'd1, 32'h200, 1'b1);
    tick("bltu");
    chk("bltu_taken", Br_taken, 0);
    req(3'd1, 32'd0, 32'd9, 32'h20C, 1'b1);
    tick("bez");
    req(3'd6, 32'd3, 32'hFFFF_FFFE, 32'h210, 1'b0);
    tick("bge");
    in_valid = 1'b0;
    tick("drain1");

    // Backpressure: result must hold while a second request waits
    out_ready = 1'b0;
    req(3'd2, 32'd1, 32'd2, 32'h100, 1'b1);
    tick("stall_acc");
    req(3'd4, 32'd3, 32'd4, 32'h108, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall_ready", in_ready, 0);
      chk("stall_taken", Br_taken, 1);
    end
    out_ready = 1'b1;
    tick("b2b0");
    chk("b2b0_taken", Br_taken, 0);
    req(3'd3, 32'd0, 32'd0, 32'h10C, 1'b0);
    tick("b2b1");
    chk("b2b1_valid", out_valid, 1);
    chk("jmp_mispred", mispredict, 1);
    in_valid = 1'b0;
    tick("drain2");

    // Saturation at index 1, JMP must leave the counter alone
    for (int i = 0; i < 4; i++) begin
      req(3'd2, 32'd1, 32'd2, 32'h84, 1'b1);
      tick("sat_up");
    end
    req(3'd2, 32'd4, 32'd4, 32'h84, 1'b1);
    tick("sat_nt");
    chk("sat_pred", pred_taken, 1);
    req(3'd3, 32'd0, 32'd0, 32'h84, 1'b1);
    tick("jmp84");
    req(3'd2, 32'd4, 32'd4, 32'h84, 1'b1);
    tick("nt2");
    in_valid = 1'b0;
    lookup_pc = 32'h84;
    #1;
    chk("jmp_noupd_pred", pred_taken, 0);
    req(3'd0, 32'd0, 32'd0, 32'h84, 1'b1);
    tick("idle");
    chk("idle_mispred", mispredict, 0);
    in_valid = 1'b0;
    lookup_pc = 32'h1084;
    #1;
    chk("alias_1084", pred_taken, 0);
    lookup_pc = 32'h1040;
    #1;
    chk("alias_1040", pred_taken, 1);
    tick("drain3");

    // Reset in the middle of a stall discards the held result
    out_ready = 1'b0;
    req(3'd4, 32'd7, 32'd7, 32'h84, 1'b0);
    tick("rs_acc");
    in_valid = 1'b0;
    tick("rs_hold");
    rst = 1'b1;
    req(3'd4, 32'd7, 32'd7, 32'h84, 1'b0);
    tick("rs_rst");
    chk("rs_valid", out_valid, 0);
    chk("rs_count", mispred_count, 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick("rs_idle");
    for (int i = 0; i < PHT_DEPTH; i++) begin
      lookup_pc = 32'(i) << IDX_LSB;
      #1;
      chk("rs_pht_pred", pred_taken, 0);
    end
    req(3'd4, 32'd7, 32'd7, 32'h84, 1'b1);
    tick("rs_wk");
    in_valid = 1'b0;
    lookup_pc = 32'h84;
    #1;
    chk("rs_pht_01", pred_taken, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and PC width in bits.
REQ-002 SHALL have parameter PHT_DEPTH, default 16: number of 2-bit predictor counters; power of 2, at least 2.
REQ-003 SHALL have parameter IDX_LSB, default 2: lowest PC bit used as the predictor index.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port lookup_pc  in  WIDTH  PC of the branch being fetched.
REQ-007 SHALL have port pred_taken  out  1  combinational prediction for lookup_pc.
REQ-008 SHALL have port in_valid  in  1  resolve request present.
REQ-009 SHALL have port in_ready  out  1  unit can accept a resolve request.
REQ-010 SHALL have port res_pc  in  WIDTH  PC of the branch being resolved.
REQ-011 SHALL have port val1  in  WIDTH  first operand.
REQ-012 SHALL have port val_src2  in  WIDTH  second operand.
REQ-013 SHALL have port Br_type  in  3  branch type; encoding per REQ-020.
REQ-014 SHALL have port res_pred_taken  in  1  prediction made earlier for this branch.
REQ-015 SHALL have port out_valid  out  1  registered result valid.
REQ-016 SHALL have port out_ready  in  1  consumer accepts the result.
REQ-017 SHALL have port Br_taken  out  1  registered resolved direction.
REQ-018 SHALL have port mispredict  out  1  registered; resolved direction differs from res_pred_taken.
REQ-019 SHALL have port mispred_count  out  16  saturating count of mispredicts.

Function
REQ-020 Br_type encoding SHALL be:
- 000 IDLE: not taken
- 001 BEZ: val1==0
- 010 BNE: val1!=val_src2
- 011 JMP: always taken
- 100 BEQ: val1==val_src2
- 101 BLT: signed val1<val_src2
- 110 BGE: signed val1>=val_src2
- 111 BLTU: unsigned val1<val_src2
REQ-021 Conditional types SHALL be BEZ, BNE, BEQ, BLT, BGE and BLTU; JMP and IDLE are unconditional.
REQ-022 in_ready SHALL equal (!out_valid || out_ready).
REQ-023 A request SHALL be accepted on a cycle with in_valid && in_ready; its result appears on out_valid/Br_taken/mispredict in the next cycle (latency 1).
REQ-024 While out_valid && !out_ready, out_valid, Br_taken and mispredict SHALL hold stable, and no new request is accepted.
REQ-025 out_valid SHALL clear after a cycle with out_ready high and no accepted request; accept and drain in the same cycle give back-to-back results.
REQ-026 mispredict SHALL be (Br_taken != res_pred_taken) for conditional types and JMP, and 0 for IDLE.
REQ-027 The PHT index SHALL be pc[IDX_LSB +: log2(PHT_DEPTH)] for both lookup_pc and res_pc; higher bits are ignored (aliasing).
REQ-028 pred_taken SHALL be bit 1 of the indexed counter, read combinationally.
REQ-029 On acceptance of a conditional type, the indexed counter SHALL update: +1 if taken, saturating at 3; -1 if not taken, saturating at 0.
REQ-030 JMP and IDLE SHALL NOT update the PHT.
REQ-031 When a lookup and an update hit the same index in the same cycle, pred_taken SHALL reflect the pre-update value.
REQ-032 mispred_count SHALL increment on each accepted request with mispredict=1 and saturate at 16'hFFFF.

Reset
REQ-033 On rst, the following SHALL hold:
- out_valid, Br_taken, mispredict = 0
- mispred_count = 0
- all PHT counters = 2'b01 (weakly not taken)
REQ-034 rst SHALL take priority over every other input; a request presented with rst high is discarded.
REQ-035 A held result SHALL be discarded when rst is asserted mid-stall.

Verification
REQ-036 After reset, lookup_pc=0x40 -> pred_taken=0; mispred_count=0.
REQ-037 BEQ with val1=val_src2=5, res_pred_taken=0, res_pc=0x40, out_ready=1 -> next cycle Br_taken=1, mispredict=1, mispred_count=1; lookup_pc=0x40 -> pred_taken=1.
REQ-038 BLT with val1=0xFFFFFFFF, val_src2=1 -> Br_taken=1; BLTU with the same operands -> Br_taken=0.
REQ-039 Accept a request, hold out_ready=0 for 3 cycles -> in_ready=0 and outputs stable; raise out_ready while in_valid=1 -> back-to-back results with no bubble.
REQ-040 Four taken BNE at one PC -> counter saturates at 3; one not-taken -> pred_taken stays 1. JMP at that PC -> counter unchanged.
REQ-041 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, mispred_count=0, all PHT counters = 01.
